// File: rtl/wb_ahb_pkg.sv
// Shared constants, FSM encoding and burst helpers for the AHB-Lite to Wishbone burst bridge.
package wb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WB_REQ = 3'd1;
    localparam logic [2:0] ST_RETRY  = 3'd2;
    localparam logic [2:0] ST_ERR1   = 3'd3;
    localparam logic [2:0] ST_ERR2   = 3'd4;

    function automatic logic is_xfer(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

    // Zero means "no fixed length": SINGLE and INCR stay classic cycles.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            HBURST_SINGLE, HBURST_INCR:   return 5'd0;
            default:                      return 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] burst_bte(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4:  return BTE_WRAP4;
            HBURST_WRAP8:  return BTE_WRAP8;
            HBURST_WRAP16: return BTE_WRAP16;
            default:       return BTE_LINEAR;
        endcase
    endfunction

endpackage

// File: rtl/wb_ahb_sel_enc.sv
// Byte-lane select generation with size/alignment error detection for one AHB address phase.
module wb_ahb_sel_enc #(
    parameter int SELW = 4
) (
    input  logic [$clog2(SELW)-1:0] offset,
    input  logic [2:0]              size,
    output logic [SELW-1:0]         sel,
    output logic                    err
);
    localparam int OFFW = $clog2(SELW);

    int              nbytes;
    logic [OFFW-1:0] mask;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves a latch behind.
        sel    = '0;
        err    = 1'b0;
        nbytes = 0;
        mask   = '0;
        if (int'(size) > OFFW) begin
            err = 1'b1;
        end else begin
            nbytes = 1 << size;
            mask   = OFFW'(nbytes - 1);
            if ((offset & mask) != '0) begin
                err = 1'b1;
            end else begin
                for (int i = 0; i < SELW; i++) begin
                    sel[i] = (i >= int'(offset)) && (i < int'(offset) + nbytes);
                end
            end
        end
    end

endmodule

// File: rtl/wb_ahb_burst_bridge.sv
// AHB-Lite slave to Wishbone B3 master bridge with burst tagging, bounded retry and timeout.
module wb_ahb_burst_bridge
    import wb_ahb_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int RETRY_MAX  = 3,
    parameter int WB_TIMEOUT = 255
) (
    input  logic                  ahb_hclk,
    input  logic                  ahb_hreset,
    input  logic                  ahb_hsel,
    input  logic                  ahb_hready_in,
    input  logic [AWIDTH-1:0]     ahb_haddr,
    input  logic [1:0]            ahb_htrans,
    input  logic                  ahb_hwrite,
    input  logic [2:0]            ahb_hsize,
    input  logic [2:0]            ahb_hburst,
    input  logic [3:0]            ahb_hprot,
    input  logic [DWIDTH-1:0]     ahb_hwdata,
    output logic [DWIDTH-1:0]     ahb_hrdata,
    output logic                  ahb_hready_out,
    output logic [1:0]            ahb_hresp,
    output logic [15:0]           ahb_hsplit,
    output logic                  wb_clk_o,
    output logic                  wb_rst_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [AWIDTH-1:0]     wb_adr_o,
    output logic [DWIDTH/8-1:0]   wb_sel_o,
    output logic [DWIDTH-1:0]     wb_dat_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [DWIDTH-1:0]     wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i
);
    localparam int SELW = DWIDTH / 8;
    localparam int OFFW = $clog2(SELW);

    logic [2:0]        state, state_nxt, addr_next;
    logic [AWIDTH-1:0] adr_r;
    logic              we_r;
    logic [SELW-1:0]   sel_r, sel_new;
    logic [2:0]        burst_r;
    logic [4:0]        beat_cnt;
    logic [7:0]        retry_cnt;
    logic [15:0]       tmo_cnt;
    logic              size_err, wb_done, addr_slot, accept, xfer, no_resp, tmo_hit, rty_fail;
    logic              unused_ok;

    assign unused_ok = ^ahb_hprot;

    wb_ahb_sel_enc #(.SELW(SELW)) u_sel_enc (
        .offset (ahb_haddr[OFFW-1:0]),
        .size   (ahb_hsize),
        .sel    (sel_new),
        .err    (size_err)
    );

    // An address phase can only land in a cycle where this slave drives hready high.
    assign wb_done   = (state == ST_WB_REQ) && wb_ack_i && !wb_err_i;
    assign addr_slot = (state == ST_IDLE) || (state == ST_ERR2) || wb_done;
    assign accept    = addr_slot && ahb_hsel && ahb_hready_in;
    assign xfer      = accept && is_xfer(ahb_htrans);
    assign no_resp   = !(wb_ack_i || wb_err_i || wb_rty_i);
    assign tmo_hit   = (WB_TIMEOUT != 0) && (tmo_cnt == 16'(WB_TIMEOUT - 1)) && no_resp;
    assign rty_fail  = (retry_cnt == 8'(RETRY_MAX));
    assign addr_next = xfer ? (size_err ? ST_ERR1 : ST_WB_REQ) : ST_IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: state_nxt = addr_next;
            ST_WB_REQ: begin
                if (wb_err_i)      state_nxt = ST_ERR1;
                else if (wb_ack_i) state_nxt = addr_next;
                else if (wb_rty_i) state_nxt = rty_fail ? ST_ERR1 : ST_RETRY;
                else if (tmo_hit)  state_nxt = ST_ERR1;
            end
            ST_RETRY: state_nxt = ST_WB_REQ;
            ST_ERR1:  state_nxt = ST_ERR2;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ahb_hclk or negedge ahb_hreset) begin
        if (!ahb_hreset) begin
            state     <= ST_IDLE;
            adr_r     <= '0;
            we_r      <= 1'b0;
            sel_r     <= '0;
            burst_r   <= HBURST_SINGLE;
            beat_cnt  <= '0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state <= state_nxt;

            if (xfer && !size_err) begin
                adr_r     <= ahb_haddr;
                we_r      <= ahb_hwrite;
                sel_r     <= sel_new;
                burst_r   <= ahb_hburst;
                retry_cnt <= '0;
            end else if ((state == ST_WB_REQ) && wb_rty_i && !wb_ack_i && !wb_err_i && !rty_fail) begin
                retry_cnt <= retry_cnt + 8'd1;
            end

            // A BUSY beat falls through to the decrement branch, leaving the count for the burst.
            if (state_nxt == ST_ERR1)
                beat_cnt <= '0;
            else if (accept && ahb_htrans == HTRANS_NONSEQ)
                beat_cnt <= burst_beats(ahb_hburst);
            else if ((accept && ahb_htrans == HTRANS_IDLE) || (addr_slot && ahb_hready_in && !ahb_hsel))
                beat_cnt <= '0;
            else if (wb_done && beat_cnt != '0)
                beat_cnt <= beat_cnt - 5'd1;

            if ((state == ST_WB_REQ) && no_resp && !tmo_hit)
                tmo_cnt <= tmo_cnt + 16'd1;
            else
                tmo_cnt <= '0;
        end
    end

    // cyc stays up across a BUSY gap of a fixed-length burst so the WB burst is not broken.
    assign wb_cyc_o = (state == ST_WB_REQ) || (state == ST_RETRY) || ((state == ST_IDLE) && beat_cnt != '0);
    assign wb_stb_o = (state == ST_WB_REQ);
    assign wb_we_o  = (state == ST_WB_REQ) && we_r;
    assign wb_adr_o = adr_r;
    assign wb_sel_o = wb_cyc_o ? sel_r : '0;
    assign wb_dat_o = ahb_hwdata;
    assign wb_cti_o = !wb_cyc_o         ? CTI_CLASSIC :
                      (beat_cnt > 5'd1) ? CTI_INCR    :
                      (beat_cnt == 5'd1) ? CTI_EOB    : CTI_CLASSIC;
    assign wb_bte_o = (wb_cyc_o && beat_cnt != '0) ? burst_bte(burst_r) : BTE_LINEAR;
    assign wb_clk_o = ahb_hclk;
    assign wb_rst_o = ~ahb_hreset;

    assign ahb_hrdata     = wb_dat_i;
    assign ahb_hsplit     = '0;
    assign ahb_hready_out = (state == ST_IDLE) || (state == ST_ERR2) || wb_done;
    assign ahb_hresp      = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_wb_ahb_burst_bridge.sv
// Directed self-checking bench for wb_ahb_burst_bridge (32-bit data, RETRY_MAX=3, WB_TIMEOUT=255).
module tb_wb_ahb_burst_bridge;
    import wb_ahb_pkg::*;

    logic        ahb_hclk = 1'b0;
    logic        ahb_hreset = 1'b0;
    logic        ahb_hsel = 1'b0;
    logic        ahb_hready_in;
    logic [31:0] ahb_haddr = '0;
    logic [1:0]  ahb_htrans = 2'b00;
    logic        ahb_hwrite = 1'b0;
    logic [2:0]  ahb_hsize = 3'd2;
    logic [2:0]  ahb_hburst = 3'd0;
    logic [3:0]  ahb_hprot = 4'h0;
    logic [31:0] ahb_hwdata = '0;
    logic [31:0] ahb_hrdata;
    logic        ahb_hready_out;
    logic [1:0]  ahb_hresp;
    logic [15:0] ahb_hsplit;
    logic        wb_clk_o, wb_rst_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [14:0] wb_ctl;
    assign wb_ctl = {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o, ahb_hready_out, ahb_hresp};

    // The bus hready is just this slave's hready in a one-slave fabric.
    assign ahb_hready_in = ahb_hready_out;

    always #5 ahb_hclk = ~ahb_hclk;

    wb_ahb_burst_bridge dut (
        .ahb_hclk(ahb_hclk), .ahb_hreset(ahb_hreset), .ahb_hsel(ahb_hsel),
        .ahb_hready_in(ahb_hready_in), .ahb_haddr(ahb_haddr), .ahb_htrans(ahb_htrans),
        .ahb_hwrite(ahb_hwrite), .ahb_hsize(ahb_hsize), .ahb_hburst(ahb_hburst),
        .ahb_hprot(ahb_hprot), .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata),
        .ahb_hready_out(ahb_hready_out), .ahb_hresp(ahb_hresp), .ahb_hsplit(ahb_hsplit),
        .wb_clk_o(wb_clk_o), .wb_rst_o(wb_rst_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    function automatic logic [14:0] ctl(input logic cyc, input logic stb, input logic we,
                                        input logic [3:0] sel, input logic [2:0] cti,
                                        input logic [1:0] bte, input logic rdy, input logic [1:0] resp);
        return {cyc, stb, we, sel, cti, bte, rdy, resp};
    endfunction

    localparam logic [14:0] IDLE_CTL = 15'b000_0000_000_00_1_00;
    localparam logic [14:0] ERR1_CTL = 15'b000_0000_000_00_0_01;
    localparam logic [14:0] ERR2_CTL = 15'b000_0000_000_00_1_01;

    task automatic tick();
        @(posedge ahb_hclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic addr_phase(input logic [1:0] trans, input logic [31:0] addr, input logic write,
                              input logic [2:0] size, input logic [2:0] burst);
        ahb_hsel   = 1'b1;
        ahb_htrans = trans;
        ahb_haddr  = addr;
        ahb_hwrite = write;
        ahb_hsize  = size;
        ahb_hburst = burst;
    endtask

    task automatic idle_bus();
        ahb_htrans = HTRANS_IDLE;
    endtask

    task automatic slave(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
        wb_ack_i = ack;
        wb_err_i = err;
        wb_rty_i = rty;
        wb_dat_i = dat;
    endtask

    task automatic test_reset();
        ahb_hreset = 1'b0;
        #12;
        tests_run++;
        if ({wb_ctl, wb_rst_o, wb_adr_o, ahb_hsplit} !== {IDLE_CTL, 1'b1, 32'h0, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: got %b/%b/%h/%h expected %b/1/0/0", wb_ctl, wb_rst_o, wb_adr_o, ahb_hsplit, IDLE_CTL);
        end
        @(negedge ahb_hclk);
        ahb_hreset = 1'b1;
        tick();
        tests_run++;
        if ({wb_ctl, wb_rst_o} !== {IDLE_CTL, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_release: got %b/%b expected %b/0", wb_ctl, wb_rst_o, IDLE_CTL);
        end
    endtask

    task automatic test_single_write();
        logic [14:0] exp;
        addr_phase(HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2, HBURST_SINGLE);
        tick();
        idle_bus();
        ahb_hwdata = 32'hCAFE_F00D;
        slave(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        exp = ctl(1, 1, 1, 4'b1111, CTI_CLASSIC, BTE_LINEAR, 1, HRESP_OKAY);
        tests_run++;
        if ({wb_ctl, wb_adr_o, wb_dat_o} !== {exp, 32'h10, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL single_write: got %b/%h/%h expected %b/00000010/cafef00d", wb_ctl, wb_adr_o, wb_dat_o, exp);
        end
        tick();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        tests_run++;
        if (wb_ctl !== IDLE_CTL) begin
            tests_failed++;
            $display("FAIL single_write_end: got %b expected %b", wb_ctl, IDLE_CTL);
        end
        tick();
    endtask

    task automatic test_sel_align();
        logic [31:0] t_addr [6] = '{32'h03, 32'h02, 32'h00, 32'h01, 32'h08, 32'h06};
        logic [2:0]  t_size [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd2};
        logic [3:0]  t_sel  [6] = '{4'b1000, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        logic        t_err  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [14:0] exp;
        for (int i = 0; i < 6; i++) begin
            addr_phase(HTRANS_NONSEQ, t_addr[i], 1'b0, t_size[i], HBURST_SINGLE);
            tick();
            idle_bus();
            if (!t_err[i]) begin
                slave(1'b1, 1'b0, 1'b0, 32'hA500_0000 + i);
                settle();
                exp = ctl(1, 1, 0, t_sel[i], CTI_CLASSIC, BTE_LINEAR, 1, HRESP_OKAY);
                tests_run++;
                if ({wb_ctl, ahb_hrdata} !== {exp, 32'hA500_0000 + i}) begin
                    tests_failed++;
                    $display("FAIL sel_%0d: got %b/%h expected %b/%h", i, wb_ctl, ahb_hrdata, exp, 32'hA500_0000 + i);
                end
                tick();
                slave(1'b0, 1'b0, 1'b0, 32'h0);
            end else begin
                settle();
                tests_run++;
                if (wb_ctl !== ERR1_CTL) begin
                    tests_failed++;
                    $display("FAIL align_err1_%0d: got %b expected %b", i, wb_ctl, ERR1_CTL);
                end
                tick();
                settle();
                tests_run++;
                if (wb_ctl !== ERR2_CTL) begin
                    tests_failed++;
                    $display("FAIL align_err2_%0d: got %b expected %b", i, wb_ctl, ERR2_CTL);
                end
                tick();
            end
        end
    endtask

    task automatic test_err2_accept();
        logic [14:0] exp;
        addr_phase(HTRANS_NONSEQ, 32'h01, 1'b1, 3'd1, HBURST_SINGLE);
        tick();
        idle_bus();
        tick();
        addr_phase(HTRANS_NONSEQ, 32'h14, 1'b1, 3'd2, HBURST_SINGLE);
        settle();
        tests_run++;
        if (wb_ctl !== ERR2_CTL) begin
            tests_failed++;
            $display("FAIL err2_accept_err2: got %b expected %b", wb_ctl, ERR2_CTL);
        end
        tick();
        idle_bus();
        slave(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        exp = ctl(1, 1, 1, 4'b1111, CTI_CLASSIC, BTE_LINEAR, 1, HRESP_OKAY);
        tests_run++;
        if ({wb_ctl, wb_adr_o} !== {exp, 32'h14}) begin
            tests_failed++;
            $display("FAIL err2_accept_beat: got %b/%h expected %b/00000014", wb_ctl, wb_adr_o, exp);
        end
        tick();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_idle_busy();
        addr_phase(HTRANS_IDLE, 32'h70, 1'b1, 3'd2, HBURST_SINGLE);
        tick();
        addr_phase(HTRANS_BUSY, 32'h70, 1'b1, 3'd2, HBURST_SINGLE);
        settle();
        tests_run++;
        if (wb_ctl !== IDLE_CTL) begin
            tests_failed++;
            $display("FAIL idle_dphase: got %b expected %b", wb_ctl, IDLE_CTL);
        end
        tick();
        idle_bus();
        settle();
        tests_run++;
        if (wb_ctl !== IDLE_CTL) begin
            tests_failed++;
            $display("FAIL busy_dphase: got %b expected %b", wb_ctl, IDLE_CTL);
        end
        tick();
    endtask

    task automatic test_incr4_read();
        logic [14:0] exp;
        logic [2:0]  cti;
        addr_phase(HTRANS_NONSEQ, 32'h20, 1'b0, 3'd2, HBURST_INCR4);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b < 3) addr_phase(HTRANS_SEQ, 32'h24 + 4 * b, 1'b0, 3'd2, HBURST_INCR4);
            else       idle_bus();
            slave(1'b1, 1'b0, 1'b0, 32'h1000 + b);
            settle();
            cti = (b == 3) ? CTI_EOB : CTI_INCR;
            exp = ctl(1, 1, 0, 4'b1111, cti, BTE_LINEAR, 1, HRESP_OKAY);
            tests_run++;
            if ({wb_ctl, wb_adr_o, ahb_hrdata} !== {exp, 32'h20 + 4 * b, 32'h1000 + b}) begin
                tests_failed++;
                $display("FAIL incr4_beat%0d: got %b/%h/%h expected %b/%h/%h", b, wb_ctl, wb_adr_o, ahb_hrdata,
                         exp, 32'h20 + 4 * b, 32'h1000 + b);
            end
            tick();
        end
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        tests_run++;
        if (wb_ctl !== IDLE_CTL) begin
            tests_failed++;
            $display("FAIL incr4_end: got %b expected %b", wb_ctl, IDLE_CTL);
        end
        tick();
    endtask

    task automatic test_retry();
        logic [14:0] exp;
        for (int run = 0; run < 2; run++) begin
            addr_phase(HTRANS_NONSEQ, 32'h40, 1'b1, 3'd2, HBURST_SINGLE);
            tick();
            idle_bus();
            for (int r = 0; r < 3 + run; r++) begin
                slave(1'b0, 1'b0, 1'b1, 32'h0);
                settle();
                exp = ctl(1, 1, 1, 4'b1111, CTI_CLASSIC, BTE_LINEAR, 0, HRESP_OKAY);
                tests_run++;
                if (wb_ctl !== exp) begin
                    tests_failed++;
                    $display("FAIL retry%0d_rty%0d: got %b expected %b", run, r, wb_ctl, exp);
                end
                tick();
                if (r < 3) begin
                    slave(1'b0, 1'b0, 1'b0, 32'h0);
                    settle();
                    exp = ctl(1, 0, 0, 4'b1111, CTI_CLASSIC, BTE_LINEAR, 0, HRESP_OKAY);
                    tests_run++;
                    if (wb_ctl !== exp) begin
                        tests_failed++;
                        $display("FAIL retry%0d_gap%0d: got %b expected %b", run, r, wb_ctl, exp);
                    end
                    tick();
                end
            end
            if (run == 0) begin
                slave(1'b1, 1'b0, 1'b0, 32'h0);
                settle();
                exp = ctl(1, 1, 1, 4'b1111, CTI_CLASSIC, BTE_LINEAR, 1, HRESP_OKAY);
                tests_run++;
                if (wb_ctl !== exp) begin
                    tests_failed++;
                    $display("FAIL retry_ok: got %b expected %b", wb_ctl, exp);
                end
                tick();
                slave(1'b0, 1'b0, 1'b0, 32'h0);
            end else begin
                slave(1'b0, 1'b0, 1'b0, 32'h0);
                settle();
                tests_run++;
                if (wb_ctl !== ERR1_CTL) begin
                    tests_failed++;
                    $display("FAIL retry_err1: got %b expected %b", wb_ctl, ERR1_CTL);
                end
                tick();
                settle();
                tests_run++;
                if (wb_ctl !== ERR2_CTL) begin
                    tests_failed++;
                    $display("FAIL retry_err2: got %b expected %b", wb_ctl, ERR2_CTL);
                end
                tick();
            end
        end
    endtask

    task automatic test_err_wins();
        logic [14:0] exp;
        addr_phase(HTRANS_NONSEQ, 32'h30, 1'b0, 3'd2, HBURST_SINGLE);
        tick();
        idle_bus();
        slave(1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        exp = ctl(1, 1, 0, 4'b1111, CTI_CLASSIC, BTE_LINEAR, 0, HRESP_OKAY);
        tests_run++;
        if (wb_ctl !== exp) begin
            tests_failed++;
            $display("FAIL err_wins_dphase: got %b expected %b", wb_ctl, exp);
        end
        tick();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        tests_run++;
        if (wb_ctl !== ERR1_CTL) begin
            tests_failed++;
            $display("FAIL err_wins_err1: got %b expected %b", wb_ctl, ERR1_CTL);
        end
        tick();
        settle();
        tests_run++;
        if (wb_ctl !== ERR2_CTL) begin
            tests_failed++;
            $display("FAIL err_wins_err2: got %b expected %b", wb_ctl, ERR2_CTL);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        addr_phase(HTRANS_NONSEQ, 32'h50, 1'b0, 3'd2, HBURST_SINGLE);
        tick();
        idle_bus();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        n = 0;
        while (wb_stb_o === 1'b1 && n < 400) begin
            n++;
            tick();
            settle();
        end
        tests_run++;
        if (n !== 255) begin
            tests_failed++;
            $display("FAIL timeout_len: got %0d stb cycles expected 255", n);
        end
        tests_run++;
        if (wb_ctl !== ERR1_CTL) begin
            tests_failed++;
            $display("FAIL timeout_err1: got %b expected %b", wb_ctl, ERR1_CTL);
        end
        tick();
        settle();
        tests_run++;
        if (wb_ctl !== ERR2_CTL) begin
            tests_failed++;
            $display("FAIL timeout_err2: got %b expected %b", wb_ctl, ERR2_CTL);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [14:0] exp;
        addr_phase(HTRANS_NONSEQ, 32'h60, 1'b1, 3'd2, HBURST_WRAP4);
        tick();
        addr_phase(HTRANS_SEQ, 32'h64, 1'b1, 3'd2, HBURST_WRAP4);
        slave(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        exp = ctl(1, 1, 1, 4'b1111, CTI_INCR, BTE_WRAP4, 1, HRESP_OKAY);
        tests_run++;
        if ({wb_ctl, wb_adr_o} !== {exp, 32'h60}) begin
            tests_failed++;
            $display("FAIL rstmid_beat1: got %b/%h expected %b/00000060", wb_ctl, wb_adr_o, exp);
        end
        tick();
        addr_phase(HTRANS_SEQ, 32'h68, 1'b1, 3'd2, HBURST_WRAP4);
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        exp = ctl(1, 1, 1, 4'b1111, CTI_INCR, BTE_WRAP4, 0, HRESP_OKAY);
        tests_run++;
        if ({wb_ctl, wb_adr_o} !== {exp, 32'h64}) begin
            tests_failed++;
            $display("FAIL rstmid_stall: got %b/%h expected %b/00000064", wb_ctl, wb_adr_o, exp);
        end
        ahb_hreset = 1'b0;
        #1;
        tests_run++;
        if ({wb_ctl, wb_rst_o, wb_adr_o} !== {IDLE_CTL, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL rstmid_async: got %b/%b/%h expected %b/1/00000000", wb_ctl, wb_rst_o, wb_adr_o, IDLE_CTL);
        end
        idle_bus();
        tick();
        ahb_hreset = 1'b1;
        tick();
        settle();
        tests_run++;
        if (wb_ctl !== IDLE_CTL) begin
            tests_failed++;
            $display("FAIL rstmid_after: got %b expected %b", wb_ctl, IDLE_CTL);
        end
        tick();
    endtask

    task automatic test_wrap8_busy();
        logic [31:0] wadr [8] = '{32'h88, 32'h8C, 32'h90, 32'h94, 32'h98, 32'h9C, 32'h80, 32'h84};
        logic [14:0] exp;
        logic [2:0]  cti;
        addr_phase(HTRANS_NONSEQ, wadr[0], 1'b0, 3'd2, HBURST_WRAP8);
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b < 2) addr_phase(HTRANS_SEQ, wadr[b + 1], 1'b0, 3'd2, HBURST_WRAP8);
            else       addr_phase(HTRANS_BUSY, wadr[3], 1'b0, 3'd2, HBURST_WRAP8);
            slave(1'b1, 1'b0, 1'b0, 32'h2000 + b);
            settle();
            exp = ctl(1, 1, 0, 4'b1111, CTI_INCR, BTE_WRAP8, 1, HRESP_OKAY);
            tests_run++;
            if ({wb_ctl, wb_adr_o} !== {exp, wadr[b]}) begin
                tests_failed++;
                $display("FAIL wrap8_beat%0d: got %b/%h expected %b/%h", b, wb_ctl, wb_adr_o, exp, wadr[b]);
            end
            tick();
        end
        addr_phase(HTRANS_SEQ, wadr[3], 1'b0, 3'd2, HBURST_WRAP8);
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        exp = ctl(1, 0, 0, 4'b1111, CTI_INCR, BTE_WRAP8, 1, HRESP_OKAY);
        tests_run++;
        if (wb_ctl !== exp) begin
            tests_failed++;
            $display("FAIL wrap8_busy: got %b expected %b", wb_ctl, exp);
        end
        tick();
        for (int b = 3; b < 8; b++) begin
            if (b < 7) addr_phase(HTRANS_SEQ, wadr[b + 1], 1'b0, 3'd2, HBURST_WRAP8);
            else       idle_bus();
            slave(1'b1, 1'b0, 1'b0, 32'h2000 + b);
            settle();
            cti = (b == 7) ? CTI_EOB : CTI_INCR;
            exp = ctl(1, 1, 0, 4'b1111, cti, BTE_WRAP8, 1, HRESP_OKAY);
            tests_run++;
            if ({wb_ctl, wb_adr_o} !== {exp, wadr[b]}) begin
                tests_failed++;
                $display("FAIL wrap8_beat%0d: got %b/%h expected %b/%h", b, wb_ctl, wb_adr_o, exp, wadr[b]);
            end
            tick();
        end
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        tests_run++;
        if (wb_ctl !== IDLE_CTL) begin
            tests_failed++;
            $display("FAIL wrap8_end: got %b expected %b", wb_ctl, IDLE_CTL);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_sel_align();
        test_err2_accept();
        test_idle_busy();
        test_incr4_read();
        test_retry();
        test_err_wins();
        test_timeout();
        test_reset_mid_burst();
        test_wrap8_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
